// File: rtl/mul_arbiter_if.sv
// rtl/mul_arbiter_if.sv - requester and multiplier-side signals of the shared multiplier arbiter
interface mul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int WIDTH = 32
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] opa;
  logic [N_REQ*WIDTH-1:0] opb;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic [2*WIDTH-1:0]     result;
  logic [ID_W-1:0]        result_id;
  logic                   err;
  logic                   mul_rst;
  logic                   mul_run;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;
  logic                   mul_ready;
  logic [2*WIDTH-1:0]     mul_product;

  modport slave (
    input  req, opa, opb, mul_ready, mul_product,
    output grant, done, result, result_id, err, mul_rst, mul_run, mul_a, mul_b
  );

  modport master (
    output req, opa, opb, mul_ready, mul_product,
    input  grant, done, result, result_id, err, mul_rst, mul_run, mul_a, mul_b
  );
endinterface

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin arbiter and run sequencer for one shared shift-add multiplier
// Optional RUN watchdog enabled by defining MUL_TIMEOUT_EN.
module mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic         clk,
  input  logic         rst,
  mul_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, owner_q, owner_d;
  logic [N_REQ-1:0]   grant_q, grant_d, done_q, done_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [ID_W-1:0]    result_id_q, result_id_d;
  logic               err_q, err_d;
  logic               mul_rst_q, mul_rst_d, mul_run_q, mul_run_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic               run_timeout;

`ifdef MUL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic [WIDTH-1:0] opa_arr [N_REQ];
  logic [WIDTH-1:0] opb_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign opa_arr[g] = bus.opa[g*WIDTH +: WIDTH];
    assign opb_arr[g] = bus.opb[g*WIDTH +: WIDTH];
  end

  // Search from ptr upwards first; fall back to the full vector to wrap around.
  logic [N_REQ-1:0] hi_mask, req_hi, pick_vec;
  logic [IDX_W-1:0] win;

  always_comb begin
    hi_mask  = ~((N_REQ'(1) << ptr_q) - N_REQ'(1));
    req_hi   = bus.req & hi_mask;
    pick_vec = (req_hi != '0) ? req_hi : bus.req;
    win      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pick_vec[i[IDX_W-1:0]]) win = i[IDX_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    done_d      = '0;
    result_d    = result_q;
    result_id_d = result_id_q;
    err_d       = err_q;
    mul_rst_d   = mul_rst_q;
    mul_run_d   = mul_run_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    run_timeout = 1'b0;
`ifdef MUL_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        grant_d   = '0;
        mul_rst_d = 1'b1;
        mul_run_d = 1'b0;
        if (bus.req != '0) begin
          state_d   = RUN;
          owner_d   = win;
          grant_d   = N_REQ'(1) << win;
          mul_a_d   = opa_arr[win];
          mul_b_d   = opb_arr[win];
          mul_rst_d = 1'b0;
          mul_run_d = 1'b1;
`ifdef MUL_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      RUN: begin
`ifdef MUL_TIMEOUT_EN
        run_timeout = !bus.mul_ready && (cnt_q == CNT_W'(TIMEOUT));
        cnt_d       = cnt_q + CNT_W'(1);
`endif
        if (bus.mul_ready || run_timeout) begin
          state_d     = DONE;
          done_d      = grant_q;
          result_d    = run_timeout ? '0 : bus.mul_product;
          result_id_d = ID_W'(owner_q);
          err_d       = run_timeout;
          grant_d     = '0;
          mul_run_d   = 1'b0;
          mul_rst_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      result_q    <= '0;
      result_id_q <= '0;
      err_q       <= 1'b0;
      mul_rst_q   <= 1'b1;
      mul_run_q   <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
`ifdef MUL_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_id_q <= result_id_d;
      err_q       <= err_d;
      mul_rst_q   <= mul_rst_d;
      mul_run_q   <= mul_run_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
`ifdef MUL_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.result_id = result_id_q;
  assign bus.err       = err_q;
  assign bus.mul_rst   = mul_rst_q;
  assign bus.mul_run   = mul_run_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
endmodule
